mul_bc2_seq: RTL and testbench

Iterative, parametrised two's-complement multiplier with saturation and an optional fixed-point scale. It is the sequential successor to the combinational 8-bit saturating scalar multiplier. It replaces the unrolled shift-and-add array with one add per clock, adds a start/done handshake, and generalises operand width and fractional bits. It sits behind the HPS-facing register/bus logic as a shared multiply unit.

---
 rtl/mul_bc2_seq.sv | 181 ++++++++++++++++++
 tb/tb_mul_bc2_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_bc2_seq.sv
// mul_bc2_seq: iterative signed multiplier, one shift-and-add per clock.
// Magnitudes are multiplied unsigned, the sign is applied afterwards, then the
// product is scaled by an arithmetic right shift of FRAC bits and saturated
// to WIDTH bits. A start/ready handshake admits one operation at a time.
module mul_bc2_seq #(
  parameter int WIDTH = 8,
  parameter int FRAC  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0]     ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]        ONE_P   = {{(PW-1){1'b0}}, 1'b1};
  // Saturation bounds, sign-extended to the full product width.
  localparam logic signed [PW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // Magnitude of a two's-complement value as an unsigned number of the same
  // width; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + ONE_W;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Two's-complement negation of the full-width product when sign is set.
  function automatic logic [PW-1:0] apply_sign(input logic neg,
                                               input logic [PW-1:0] mag);
    logic [PW-1:0] r;
    if (neg) begin
      r = ~mag + ONE_P;
    end else begin
      r = mag;
    end
    return r;
  endfunction

  // Clamp a scaled product to WIDTH bits; returns {overflow, result}.
  function automatic logic [WIDTH:0] saturate(input logic signed [PW-1:0] s);
    logic [WIDTH:0] r;
    if (s > SAT_MAX) begin
      r = {1'b1, SAT_MAX[WIDTH-1:0]};
    end else if (s < SAT_MIN) begin
      r = {1'b1, SAT_MIN[WIDTH-1:0]};
    end else begin
      r = {1'b0, s[WIDTH-1:0]};
    end
    return r;
  endfunction

  state_e             state_q,  state_d;
  logic               sign_q,   sign_d;
  logic [WIDTH-1:0]   mag_a_q,  mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,  mag_b_d;
  logic [PW-1:0]      acc_q,    acc_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q,    ovf_d;
  logic               done_q,   done_d;
  logic               ready_q,  ready_d;

  logic [PW-1:0]        part_s;
  logic [PW-1:0]        prod_s;
  logic signed [PW-1:0] scaled_s;
  logic [WIDTH:0]       sat_s;

  // Datapath terms: shifted partial product and the scaled, saturated result.
  always_comb begin
    part_s   = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;
    prod_s   = apply_sign(sign_q, acc_q);
    scaled_s = $signed(prod_s) >>> FRAC;
    sat_s    = saturate(scaled_s);
  end

  // Next-state and register-update logic for the IDLE/MUL/FIX sequence.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          mag_a_d = abs_u(a);
          mag_b_d = abs_u(b);
          acc_d   = {PW{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mag_b_q[cnt_q]) begin
          acc_d = acc_q + part_s;
        end else begin
          acc_d = acc_q;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        result_d = sat_s[WIDTH-1:0];
        ovf_d    = sat_s[WIDTH];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      mag_a_q  <= {WIDTH{1'b0}};
      mag_b_q  <= {WIDTH{1'b0}};
      acc_q    <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = ~ready_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_mul_bc2_seq.sv
// Bench for mul_bc2_seq: four instances (W8/F0, W8/F4, W4/F0, W16/F0) with a
// scoreboard queue filled at accept time and drained when done pulses.
module tb_mul_bc2_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic st [4];
  logic rdy [4];
  logic bsy [4];
  logic dn [4];
  logic ov [4];

  logic signed [7:0]  a8, b8, r8;
  logic signed [7:0]  a8f, b8f, r8f;
  logic signed [3:0]  a4, b4, r4;
  logic signed [15:0] a16, b16, r16;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int res;
    bit ovf;
  } exp_t;
  exp_t sb [$];

  mul_bc2_seq #(.WIDTH(8), .FRAC(0)) u_w8 (
    .clk(clk), .reset(reset), .start(st[0]), .a(a8), .b(b8),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .result(r8), .overflow(ov[0]));
  mul_bc2_seq #(.WIDTH(8), .FRAC(4)) u_w8f (
    .clk(clk), .reset(reset), .start(st[1]), .a(a8f), .b(b8f),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .result(r8f), .overflow(ov[1]));
  mul_bc2_seq #(.WIDTH(4), .FRAC(0)) u_w4 (
    .clk(clk), .reset(reset), .start(st[2]), .a(a4), .b(b4),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .result(r4), .overflow(ov[2]));
  mul_bc2_seq #(.WIDTH(16), .FRAC(0)) u_w16 (
    .clk(clk), .reset(reset), .start(st[3]), .a(a16), .b(b16),
    .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .result(r16), .overflow(ov[3]));

  function automatic int dw(input int d);
    case (d)
      0: return 8;
      1: return 8;
      2: return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int dfrac(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  function automatic int get_res(input int d);
    case (d)
      0: return int'(r8);
      1: return int'(r8f);
      2: return int'(r4);
      default: return int'(r16);
    endcase
  endfunction

  // Golden saturating model: exact product, floor shift, clamp.
  function automatic int model(input int av, input int bv, input int w,
                               input int frac, output bit ovf);
    longint p, s, mx, mn;
    p  = longint'(av) * longint'(bv);
    s  = p >>> frac;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    ovf = 1'b0;
    if (s > mx) begin
      ovf = 1'b1;
      s = mx;
    end else if (s < mn) begin
      ovf = 1'b1;
      s = mn;
    end
    return int'(s);
  endfunction

  task automatic set_ops(input int d, input int av, input int bv);
    case (d)
      0: begin a8 = av[7:0]; b8 = bv[7:0]; end
      1: begin a8f = av[7:0]; b8f = bv[7:0]; end
      2: begin a4 = av[3:0]; b4 = bv[3:0]; end
      default: begin a16 = av[15:0]; b16 = bv[15:0]; end
    endcase
  endtask

  // Drive one start pulse (caller is away from the edge); optionally score it.
  task automatic issue(input int d, input int av, input int bv, input bit push);
    exp_t e;
    bit o;
    checks++;
    if (rdy[d] !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready dut%0d ready=%b required 1", d, rdy[d]);
    end
    set_ops(d, av, bv);
    st[d] = 1'b1;
    if (push) begin
      e.res = model(av, bv, dw(d), dfrac(d), o);
      e.ovf = o;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    st[d] = 1'b0;
  endtask

  // Wait (bounded) for done, then compare latency and the scoreboard head.
  task automatic wait_done(input int d);
    int lat;
    bit got;
    exp_t e;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (dn[d] === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout dut%0d no done within %0d cycles", d, lat);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      failures++;
      $display("FAIL spurious_done dut%0d done with empty scoreboard", d);
    end else begin
      e = sb.pop_front();
      if (lat != dw(d) + 1) begin
        failures++;
        $display("FAIL latency dut%0d got %0d required %0d", d, lat, dw(d) + 1);
      end
      checks++;
      if (get_res(d) !== e.res) begin
        failures++;
        $display("FAIL result dut%0d got %0d required %0d", d, get_res(d), e.res);
      end
      checks++;
      if (ov[d] !== e.ovf) begin
        failures++;
        $display("FAIL overflow dut%0d got %b required %b", d, ov[d], e.ovf);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int d = 0; d < 4; d++) st[d] = 1'b0;
    for (int d = 0; d < 4; d++) set_ops(d, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0 || dn[d] !== 1'b0 ||
          get_res(d) !== 0 || ov[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state dut%0d rdy=%b bsy=%b done=%b res=%0d ovf=%b required 1 0 0 0 0",
                 d, rdy[d], bsy[d], dn[d], get_res(d), ov[d]);
      end
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int av [5] = '{5, 16, -16, -128, -128};
    int bv [5] = '{-6, 16, 9, -128, 1};
    for (int i = 0; i < 5; i++) begin
      issue(0, av[i], bv[i], 1'b1);
      wait_done(0);
    end
  endtask

  task automatic test_frac();
    int av [3] = '{24, -1, 127};
    int bv [3] = '{40, 1, 127};
    for (int i = 0; i < 3; i++) begin
      issue(1, av[i], bv[i], 1'b1);
      wait_done(1);
    end
  endtask

  task automatic test_busy_start();
    int ndone;
    exp_t e;
    ndone = 0;
    issue(0, 7, -9, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (bsy[0] === 1'b1) begin
        set_ops(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
        st[0] = 1'b1;
      end else begin
        st[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (dn[0] === 1'b1) begin
        ndone++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (get_res(0) !== e.res || ov[0] !== e.ovf) begin
            failures++;
            $display("FAIL busy_start_result got %0d/%b required %0d/%b",
                     get_res(0), ov[0], e.res, e.ovf);
          end
        end
      end
    end
    st[0] = 1'b0;
    checks++;
    if (ndone != 1) begin
      failures++;
      $display("FAIL busy_start_done_count got %0d required 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    issue(0, 3, 4, 1'b1);
    wait_done(0);
    issue(0, 5, 6, 1'b1);
    checks++;
    if (dn[0] !== 1'b0) begin
      failures++;
      $display("FAIL done_width done=%b required 0 one cycle after pulse", dn[0]);
    end
    wait_done(0);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    issue(0, 7, 7, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bsy[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy busy=%b required 1", bsy[0]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || get_res(0) !== 0 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort_state rdy=%b bsy=%b res=%0d ovf=%b required 1 0 0 0",
               rdy[0], bsy[0], get_res(0), ov[0]);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (dn[0] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_done got %0d done pulses required 0", seen);
    end
    issue(0, 3, 3, 1'b1);
    wait_done(0);
  endtask

  task automatic test_sweep();
    issue(2, -8, -8, 1'b1);
    wait_done(2);
    for (int i = 0; i < 15; i++) begin
      issue(2, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8, 1'b1);
      wait_done(2);
    end
    issue(3, -32768, -32768, 1'b1);
    wait_done(3);
    issue(3, -32768, 1, 1'b1);
    wait_done(3);
    issue(3, 32767, 32767, 1'b1);
    wait_done(3);
    for (int i = 0; i < 15; i++) begin
      issue(3, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, 1'b1);
      wait_done(3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frac();
    test_busy_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
